// File: rtl/fetch_pkg.sv
// Shared sizing constants and slot payload for the in-order instruction fetch buffer.
package fetch_pkg;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  // Counters must represent 0..DEPTH inclusive.
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned SUM_W  = CNT_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
    logic              filled;
  } slot_t;

endpackage

// File: rtl/fetch_slot_array.sv
// Circular slot storage: allocate writes the PC, fill writes the instruction,
// one combinational read port for the head slot.
module fetch_slot_array
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_en,
  input  logic [PTR_W-1:0]  alloc_idx,
  input  logic [ADDR_W-1:0] alloc_pc,
  input  logic              fill_en,
  input  logic [PTR_W-1:0]  fill_idx,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              clear,
  input  logic [PTR_W-1:0]  rd_idx,
  output slot_t             rd_slot
);

  slot_t slots_q [DEPTH];
  slot_t slots_d [DEPTH];

  // Allocation and fill never target the same slot in one cycle.
  always_comb begin
    slots_d = slots_q;
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slots_d[i].filled = 1'b0;
      end
    end
    if (alloc_en) begin
      slots_d[alloc_idx].pc     = alloc_pc;
      slots_d[alloc_idx].filled = 1'b0;
    end
    if (fill_en) begin
      slots_d[fill_idx].data   = fill_data;
      slots_d[fill_idx].filled = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_q <= '{default: '0};
    end else begin
      slots_q <= slots_d;
    end
  end

  assign rd_slot = slots_q[rd_idx];

endmodule

// File: rtl/fetch_buffer.sv
// In-order fetch buffer: issues PC requests, tags slots, captures responses in order,
// presents {instr, pc} to decode, and drops wrong-path responses after a flush.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] PCAddress,
  output logic              PCStall,
  output logic              ImemReqValid,
  output logic [ADDR_W-1:0] ImemReqAddr,
  input  logic              ImemReqReady,
  input  logic              ImemRspValid,
  input  logic [DATA_W-1:0] ImemRspData,
  output logic              InstrValid,
  output logic [DATA_W-1:0] Instr,
  output logic [ADDR_W-1:0] InstrPC,
  input  logic              InstrReady,
  input  logic              Flush
);

  logic [PTR_W-1:0] rd_q, rd_d, alloc_q, alloc_d, fill_q, fill_d;
  logic [CNT_W-1:0] occ_q, occ_d, pend_q, pend_d, drop_q, drop_d;
  logic [SUM_W-1:0] budget, owed;
  logic             accept, pop, fill_en;
  slot_t            head;

  // Handshakes: a request slot is only offered while queued plus owed stays below DEPTH.
  always_comb begin
    budget       = SUM_W'(occ_q) + SUM_W'(drop_q);
    ImemReqValid = !Flush && (budget < SUM_W'(DEPTH));
    ImemReqAddr  = PCAddress;
    accept       = ImemReqValid && ImemReqReady;
    PCStall      = !accept;
    InstrValid   = (occ_q != '0) && head.filled && !Flush;
    Instr        = head.data;
    InstrPC      = head.pc;
    pop          = InstrValid && InstrReady;
    fill_en      = ImemRspValid && !Flush && (drop_q == '0) && (pend_q != '0);
  end

  // Pointer and counter update; a flush turns every unfilled slot into an owed response.
  always_comb begin
    rd_d    = rd_q;
    alloc_d = alloc_q;
    fill_d  = fill_q;
    occ_d   = occ_q;
    pend_d  = pend_q;
    drop_d  = drop_q;
    owed    = SUM_W'(drop_q) + SUM_W'(pend_q);
    if (Flush) begin
      rd_d    = '0;
      alloc_d = '0;
      fill_d  = '0;
      occ_d   = '0;
      pend_d  = '0;
      if (ImemRspValid && (owed != '0)) begin
        owed = owed - SUM_W'(1);
      end
      drop_d = CNT_W'(owed);
    end else begin
      alloc_d = alloc_q + PTR_W'(accept);
      rd_d    = rd_q + PTR_W'(pop);
      fill_d  = fill_q + PTR_W'(fill_en);
      occ_d   = occ_q + CNT_W'(accept) - CNT_W'(pop);
      pend_d  = pend_q + CNT_W'(accept) - CNT_W'(fill_en);
      if (ImemRspValid && (drop_q != '0)) begin
        drop_d = drop_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rd_q    <= '0;
      alloc_q <= '0;
      fill_q  <= '0;
      occ_q   <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      occ_q   <= occ_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  fetch_slot_array u_slots (
    .clk       (Clk),
    .rst_n     (Reset),
    .alloc_en  (accept),
    .alloc_idx (alloc_q),
    .alloc_pc  (PCAddress),
    .fill_en   (fill_en),
    .fill_idx  (fill_q),
    .fill_data (ImemRspData),
    .clear     (Flush),
    .rd_idx    (rd_q),
    .rd_slot   (head)
  );

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: fixed-latency memory model plus an in-order
// scoreboard of expected {pc, instr} entries checked every cycle.
module tb_fetch_buffer;
  import fetch_pkg::*;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [ADDR_W-1:0] PCAddress;
  logic              PCStall;
  logic              ImemReqValid;
  logic [ADDR_W-1:0] ImemReqAddr;
  logic              ImemReqReady;
  logic              ImemRspValid;
  logic [DATA_W-1:0] ImemRspData;
  logic              InstrValid;
  logic [DATA_W-1:0] Instr;
  logic [ADDR_W-1:0] InstrPC;
  logic              InstrReady;
  logic              Flush;

  fetch_buffer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .PCAddress    (PCAddress),
    .PCStall      (PCStall),
    .ImemReqValid (ImemReqValid),
    .ImemReqAddr  (ImemReqAddr),
    .ImemReqReady (ImemReqReady),
    .ImemRspValid (ImemRspValid),
    .ImemRspData  (ImemRspData),
    .InstrValid   (InstrValid),
    .Instr        (Instr),
    .InstrPC      (InstrPC),
    .InstrReady   (InstrReady),
    .Flush        (Flush)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; bit filled; } exp_t;

  mreq_t       mem_q[$];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          occ_m = 0;
  int          drop_m = 0;
  int          acc_cnt = 0;
  int          pop_cnt = 0;
  int          base;
  logic [31:0] first_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory response, compare against model, advance model, advance PC.
  task automatic tick();
    bit exp_rv, exp_iv, acc, pop, rsp, dut_acc;
    int pending, idx;
    rsp          = 1'b0;
    ImemRspValid = 1'b0;
    ImemRspData  = '0;
    if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      rsp          = 1'b1;
      ImemRspValid = 1'b1;
      ImemRspData  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
    #1;
    exp_rv = !Flush && (occ_m + drop_m < int'(DEPTH));
    exp_iv = !Flush && exp_q.size() > 0 && exp_q[0].filled;
    check("req_valid", 32'(ImemReqValid), 32'(exp_rv));
    check("pc_stall", 32'(PCStall), 32'(!(exp_rv && ImemReqReady)));
    check("req_addr", ImemReqAddr, PCAddress);
    check("instr_valid", 32'(InstrValid), 32'(exp_iv));
    check("occ", 32'(dut.occ_q), 32'(occ_m));
    check("drop_cnt", 32'(dut.drop_q), 32'(drop_m));
    if (exp_iv) begin
      check("instr_pc", InstrPC, exp_q[0].pc);
      check("instr", Instr, exp_q[0].data);
    end
    acc     = exp_rv && ImemReqReady;
    pop     = exp_iv && InstrReady;
    dut_acc = ImemReqValid && ImemReqReady;
    if (dut_acc) begin
      mem_q.push_back('{PCAddress, cyc + lat});
      acc_cnt++;
    end
    if (InstrValid && InstrReady) begin
      if (pop_cnt == 0) first_pc = InstrPC;
      pop_cnt++;
    end
    if (Flush) begin
      pending = 0;
      foreach (exp_q[i]) if (!exp_q[i].filled) pending++;
      if (rsp) check("rsp_owed", 32'(drop_m + pending > 0), 32'd1);
      drop_m = drop_m + pending - ((rsp && drop_m + pending > 0) ? 1 : 0);
      exp_q.delete();
    end else begin
      if (rsp) begin
        if (drop_m > 0) begin
          drop_m--;
        end else begin
          idx = -1;
          for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && !exp_q[i].filled) idx = i;
          end
          check("rsp_owed", 32'(idx >= 0), 32'd1);
          if (idx >= 0) exp_q[idx].filled = 1'b1;
        end
      end
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back('{PCAddress, mem_word(PCAddress), 1'b0});
    end
    occ_m = exp_q.size();
    @(posedge Clk);
    @(negedge Clk);
    cyc++;
    if (dut_acc) PCAddress = PCAddress + 32'd4;
  endtask

  task automatic apply_reset();
    Reset = 1'b0;
    #1;
    check("rst_instr_valid", 32'(InstrValid), 32'd0);
    check("rst_occ", 32'(dut.occ_q), 32'd0);
    check("rst_drop", 32'(dut.drop_q), 32'd0);
    mem_q.delete();
    exp_q.delete();
    occ_m        = 0;
    drop_m       = 0;
    ImemRspValid = 1'b0;
    repeat (2) @(negedge Clk);
    cyc += 2;
    check("rst_instr", Instr, 32'd0);
    check("rst_instr_pc", InstrPC, 32'd0);
    Reset = 1'b1;
  endtask

  initial begin
    Reset        = 1'b0;
    PCAddress    = '0;
    ImemReqReady = 1'b0;
    ImemRspValid = 1'b0;
    ImemRspData  = '0;
    InstrReady   = 1'b0;
    Flush        = 1'b0;
    first_pc     = '0;
    @(negedge Clk);

    // Streaming at L=1: one instruction per cycle from cycle 2.
    apply_reset();
    lat = 1; PCAddress = 32'h0; ImemReqReady = 1'b1; InstrReady = 1'b1;
    pop_cnt = 0;
    repeat (10) tick();
    check("t1_pops", 32'(pop_cnt), 32'd8);
    check("t1_first_pc", first_pc, 32'h0);

    // Decode stalled: fills to DEPTH, then drains in order and resumes at 0x10.
    apply_reset();
    PCAddress = 32'h0; InstrReady = 1'b0;
    base = acc_cnt;
    repeat (8) tick();
    check("t2_accepts", 32'(acc_cnt - base), 32'd4);
    check("t2_full_valid", 32'(ImemReqValid), 32'd0);
    check("t2_full_stall", 32'(PCStall), 32'd1);
    check("t2_held_addr", ImemReqAddr, 32'h10);
    InstrReady = 1'b1; pop_cnt = 0; base = acc_cnt;
    repeat (4) tick();
    check("t2_pops", 32'(pop_cnt), 32'd4);
    check("t2_first_pc", first_pc, 32'h0);
    check("t2_resume_acc", 32'(acc_cnt - base), 32'd3);

    // Memory not ready: PC held, nothing allocated, then exactly one accept.
    apply_reset();
    PCAddress = 32'h80; InstrReady = 1'b0; ImemReqReady = 1'b1;
    repeat (2) tick();
    ImemReqReady = 1'b0; base = acc_cnt;
    repeat (3) tick();
    check("t3_no_accept", 32'(acc_cnt - base), 32'd0);
    check("t3_occ_held", 32'(dut.occ_q), 32'd2);
    ImemReqReady = 1'b1;
    tick();
    check("t3_one_accept", 32'(acc_cnt - base), 32'd1);
    ImemReqReady = 1'b0; InstrReady = 1'b1; pop_cnt = 0;
    repeat (6) tick();
    check("t3_pops", 32'(pop_cnt), 32'd3);
    check("t3_first_pc", first_pc, 32'h80);

    // L=3, flush with two in flight: both responses dropped, new path at 0x100.
    apply_reset();
    lat = 3; PCAddress = 32'h40; ImemReqReady = 1'b1; InstrReady = 1'b1;
    repeat (2) tick();
    Flush = 1'b1; PCAddress = 32'h100;
    tick();
    Flush = 1'b0;
    check("t4_drop", 32'(dut.drop_q), 32'd2);
    pop_cnt = 0;
    repeat (12) tick();
    check("t4_first_pc", first_pc, 32'h100);
    check("t4_drained_drop", 32'(dut.drop_q), 32'd0);

    // Flush coinciding with a response, two pending: one owed afterwards.
    apply_reset();
    lat = 2; PCAddress = 32'h200;
    repeat (2) tick();
    Flush = 1'b1; PCAddress = 32'h300;
    tick();
    Flush = 1'b0;
    check("t5_drop", 32'(dut.drop_q), 32'd1);
    pop_cnt = 0;
    repeat (10) tick();
    check("t5_first_pc", first_pc, 32'h300);

    // Back-to-back flushes accumulate owed responses.
    apply_reset();
    lat = 4; PCAddress = 32'h600;
    repeat (2) tick();
    Flush = 1'b1;
    repeat (2) tick();
    Flush = 1'b0;
    check("t5b_drop", 32'(dut.drop_q), 32'd2);
    repeat (8) tick();

    // Reset mid-operation with three queued, restart from the presented PC.
    apply_reset();
    lat = 1; PCAddress = 32'h400; InstrReady = 1'b0; ImemReqReady = 1'b1;
    repeat (3) tick();
    check("t6_pre_occ", 32'(dut.occ_q), 32'd3);
    check("t6_pre_valid", 32'(InstrValid), 32'd1);
    apply_reset();
    PCAddress = 32'h500; InstrReady = 1'b1; pop_cnt = 0;
    repeat (5) tick();
    check("t6_first_pc", first_pc, 32'h500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
